// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: mode codes,
// FSM state encoding and default datapath geometry.
package shift_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_SHAMT_W = 4;

    typedef enum logic [1:0] {
        SHIFT_SRL = 2'b00,
        SHIFT_ROL = 2'b01,
        SHIFT_SAL = 2'b10,
        SHIFT_ILL = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational datapath: advances the operand by k single-bit
// sub-steps (k <= STEP) and reports the SAL sign-change term.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0]   data,
    input  shift_mode_e        mode,
    input  logic [SHAMT_W-1:0] k,
    output logic [WIDTH-1:0]   nxt,
    output logic               ovf
);

    logic [WIDTH-1:0] d;

    always_comb begin
        d   = data;
        ovf = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (SHAMT_W'(i) < k) begin
                case (mode)
                    SHIFT_SRL: d = {1'b0, d[WIDTH-1:1]};
                    SHIFT_ROL: d = {d[WIDTH-2:0], d[WIDTH-1]};
                    SHIFT_SAL: begin
                        // sign change seen before this sub-step
                        ovf = ovf | (d[WIDTH-1] ^ d[WIDTH-2]);
                        d   = {d[WIDTH-2:0], 1'b0};
                    end
                    default: d = d;
                endcase
            end
        end
        nxt = d;
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SRL/ROL/SAL unit with start/busy/done handshake.
// Define SEQ_SHIFT_ZERO_FLAG_EN to add the registered zero output.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   shift_in,
    input  logic [SHAMT_W-1:0] shift_val,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   shift_out,
    output logic               ovfl,
    output logic               err
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
    ,
    output logic               zero
`endif
);

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_e             state;
    shift_mode_e        mode_r;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] k;
    logic               acc;
    logic [WIDTH-1:0]   step_nxt;
    logic               step_ovf;
    logic               ill_in;
    logic               ill_r;
    logic [WIDTH-1:0]   result;

    assign k      = (cnt < STEP_K) ? cnt : STEP_K;
    assign ill_in = (shift_mode_e'(mode) == SHIFT_ILL);
    assign ill_r  = (mode_r == SHIFT_ILL);
    assign result = ill_r ? '0 : data;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) u_step (
        .data (data),
        .mode (mode_r),
        .k    (k),
        .nxt  (step_nxt),
        .ovf  (step_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_r    <= SHIFT_SRL;
            data      <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_out <= '0;
            ovfl      <= 1'b0;
            err       <= 1'b0;
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
            zero      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // illegal mode skips iteration entirely
                        data   <= shift_in;
                        cnt    <= ill_in ? '0 : shift_val;
                        mode_r <= shift_mode_e'(mode);
                        acc    <= 1'b0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        data <= step_nxt;
                        cnt  <= cnt - k;
                        acc  <= acc | step_ovf;
                    end else begin
                        shift_out <= result;
                        ovfl      <= acc & (mode_r == SHIFT_SAL);
                        err       <= ill_r;
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
                        zero      <= (result == '0);
`endif
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (STEP=1 and STEP=4 instances).
// Build with SEQ_SHIFT_ZERO_FLAG_EN to also exercise the zero flag.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] shift_in;
    logic [3:0]  shift_val;
    logic        busy, done, ovfl, err;
    logic [15:0] shift_out;

    logic        start4;
    logic [1:0]  mode4;
    logic [15:0] shift_in4;
    logic [3:0]  shift_val4;
    logic        busy4, done4, ovfl4, err4;
    logic [15:0] shift_out4;
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
    logic        zero, zero4;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .shift_in  (shift_in),
        .shift_val (shift_val),
        .busy      (busy),
        .done      (done),
        .shift_out (shift_out),
        .ovfl      (ovfl),
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .err       (err)
    );

    seq_shift_unit #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .mode      (mode4),
        .shift_in  (shift_in4),
        .shift_val (shift_val4),
        .busy      (busy4),
        .done      (done4),
        .shift_out (shift_out4),
        .ovfl      (ovfl4),
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        .zero      (zero4),
`endif
        .err       (err4)
    );

    task automatic launch(input logic [1:0] m, input logic [15:0] d,
                          input logic [3:0] v);
        @(negedge clk);
        start = 1'b1; mode = m; shift_in = d; shift_val = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat = edges after E0 until done is seen; bad = busy violations
    task automatic wait_done(input int n0, output int lat,
                             output int bad);
        lat = -1; bad = 0;
        if (!busy) bad++;
        for (int n = n0 + 1; n <= n0 + 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                if (busy) bad++;
                break;
            end
            if (!busy) bad++;
        end
    endtask

    task automatic launch4(input logic [1:0] m, input logic [15:0] d,
                           input logic [3:0] v);
        @(negedge clk);
        start4 = 1'b1; mode4 = m; shift_in4 = d; shift_val4 = v;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic wait_done4(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tests++; if (busy !== 1'b0) begin fails++;
            $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++;
            $display("FAIL reset_done got %b want 0", done); end
        tests++; if (shift_out !== 16'h0) begin fails++;
            $display("FAIL reset_out got %h want 0000", shift_out); end
        tests++; if (ovfl !== 1'b0) begin fails++;
            $display("FAIL reset_ovfl got %b want 0", ovfl); end
        tests++; if (err !== 1'b0) begin fails++;
            $display("FAIL reset_err got %b want 0", err); end
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        tests++; if (zero !== 1'b0) begin fails++;
            $display("FAIL reset_zero got %b want 0", zero); end
`endif
    endtask

    task automatic test_srl();
        int lat, bad;
        launch(2'b00, 16'h8001, 4'd4);
        wait_done(0, lat, bad);
        tests++; if (lat !== 5) begin fails++;
            $display("FAIL srl_lat got %0d want 5", lat); end
        tests++; if (bad !== 0) begin fails++;
            $display("FAIL srl_busy got %0d bad cycles want 0", bad); end
        tests++; if ({shift_out, ovfl, err} !== {16'h0800, 2'b00}) begin
            fails++;
            $display("FAIL srl_res got %h/%b/%b want 0800/0/0",
                     shift_out, ovfl, err); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({shift_out, done, busy} !== {16'h0800, 2'b00}) begin
            fails++;
            $display("FAIL srl_hold got %h/%b/%b want 0800/0/0",
                     shift_out, done, busy); end
    endtask

    task automatic test_rol();
        int lat, bad;
        launch(2'b01, 16'h8001, 4'd1);
        wait_done(0, lat, bad);
        tests++; if ({shift_out, ovfl} !== {16'h0003, 1'b0} || lat !== 2)
        begin fails++;
            $display("FAIL rol1 got %h/%b lat %0d want 0003/0 lat 2",
                     shift_out, ovfl, lat); end
        launch(2'b01, 16'h8001, 4'd15);
        wait_done(0, lat, bad);
        tests++; if (shift_out !== 16'hC000 || lat !== 16) begin fails++;
            $display("FAIL rol15 got %h lat %0d want c000 lat 16",
                     shift_out, lat); end
    endtask

    task automatic test_sal();
        int lat, bad;
        launch(2'b10, 16'h4000, 4'd1);
        wait_done(0, lat, bad);
        tests++; if ({shift_out, ovfl} !== {16'h8000, 1'b1}) begin fails++;
            $display("FAIL sal_4000 got %h/%b want 8000/1",
                     shift_out, ovfl); end
        launch(2'b10, 16'hFFFF, 4'd3);
        wait_done(0, lat, bad);
        tests++; if ({shift_out, ovfl} !== {16'hFFF8, 1'b0} || lat !== 4)
        begin fails++;
            $display("FAIL sal_ffff got %h/%b lat %0d want fff8/0 lat 4",
                     shift_out, ovfl, lat); end
        launch(2'b10, 16'h0001, 4'd15);
        wait_done(0, lat, bad);
        tests++; if ({shift_out, ovfl} !== {16'h8000, 1'b1}) begin fails++;
            $display("FAIL sal_0001 got %h/%b want 8000/1",
                     shift_out, ovfl); end
    endtask

    task automatic test_zero_shift();
        int lat, bad;
        launch(2'b00, 16'hA5A5, 4'd0);
        wait_done(0, lat, bad);
        tests++; if ({shift_out, ovfl, err} !== {16'hA5A5, 2'b00} ||
                     lat !== 1) begin fails++;
            $display("FAIL zero_shamt got %h/%b/%b lat %0d want a5a5 lat 1",
                     shift_out, ovfl, err, lat); end
    endtask

    task automatic test_illegal();
        int lat, bad;
        launch(2'b11, 16'h1234, 4'd5);
        wait_done(0, lat, bad);
        tests++; if ({shift_out, ovfl, err} !== {16'h0, 2'b01} ||
                     lat !== 1) begin fails++;
            $display("FAIL ill got %h/%b/%b lat %0d want 0000/0/1 lat 1",
                     shift_out, ovfl, err, lat); end
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        tests++; if (zero !== 1'b1) begin fails++;
            $display("FAIL ill_zero got %b want 1", zero); end
`endif
        launch(2'b00, 16'h0001, 4'd1);
        tests++; if (err !== 1'b0) begin fails++;
            $display("FAIL ill_clr got %b want 0", err); end
        wait_done(0, lat, bad);
        tests++; if ({shift_out, err} !== {16'h0000, 1'b0}) begin fails++;
            $display("FAIL ill_next got %h/%b want 0000/0",
                     shift_out, err); end
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        tests++; if (zero !== 1'b1) begin fails++;
            $display("FAIL srl_zero got %b want 1", zero); end
`endif
    endtask

    task automatic test_busy_ignore();
        int lat, bad;
        launch(2'b00, 16'h8001, 4'd4);
        start = 1'b1; mode = 2'b01; shift_in = 16'hFFFF; shift_val = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, lat, bad);
        tests++; if ({shift_out, ovfl} !== {16'h0800, 1'b0} || lat !== 5 ||
                     bad !== 0) begin fails++;
            $display("FAIL ignore got %h lat %0d bad %0d want 0800 lat 5",
                     shift_out, lat, bad); end
    endtask

    task automatic test_back_to_back();
        int lat, bad;
        launch(2'b01, 16'h8001, 4'd1);
        wait_done(0, lat, bad);
        tests++; if (shift_out !== 16'h0003) begin fails++;
            $display("FAIL b2b_first got %h want 0003", shift_out); end
        start = 1'b1; mode = 2'b10; shift_in = 16'h4000; shift_val = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, lat, bad);
        tests++; if ({shift_out, ovfl} !== {16'h8000, 1'b1} || lat !== 2 ||
                     bad !== 0) begin fails++;
            $display("FAIL b2b_second got %h/%b lat %0d bad %0d want 8000/1",
                     shift_out, ovfl, lat, bad); end
    endtask

    task automatic test_step4();
        int lat;
        launch4(2'b01, 16'h8001, 4'd15);
        wait_done4(lat);
        tests++; if (shift_out4 !== 16'hC000 || lat !== 5) begin fails++;
            $display("FAIL s4_rol15 got %h lat %0d want c000 lat 5",
                     shift_out4, lat); end
        launch4(2'b10, 16'h0001, 4'd15);
        wait_done4(lat);
        tests++; if ({shift_out4, ovfl4} !== {16'h8000, 1'b1} || lat !== 5)
        begin fails++;
            $display("FAIL s4_sal15 got %h/%b lat %0d want 8000/1 lat 5",
                     shift_out4, ovfl4, lat); end
        launch4(2'b00, 16'h8001, 4'd4);
        wait_done4(lat);
        tests++; if (shift_out4 !== 16'h0800 || lat !== 2) begin fails++;
            $display("FAIL s4_srl4 got %h lat %0d want 0800 lat 2",
                     shift_out4, lat); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        launch(2'b00, 16'hFFFF, 4'd10);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if ({busy, done, shift_out, ovfl, err} !== 20'h0) begin
            fails++;
            $display("FAIL rst_mid got b%b d%b %h o%b e%b want all 0",
                     busy, done, shift_out, ovfl, err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++;
            $display("FAIL rst_nodone got %0d active cycles want 0", pulses);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; mode = 2'b00; shift_in = '0; shift_val = '0;
        start4 = 1'b0; mode4 = 2'b00; shift_in4 = '0; shift_val4 = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_srl();
        test_rol();
        test_sal();
        test_zero_shift();
        test_illegal();
        test_busy_ignore();
        test_back_to_back();
        test_step4();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
